mpc_qp_admm_proj_update: RTL and testbench
==========================================

# mpc_qp_admm_proj_update

ADMM projection stage of the implicit-MPC QP solver. On `start` it sweeps the 32-bit temp RAM in place, replacing each entry with its box-clamped value. It consumes the single-port, read-first temp RAM directly downstream of the linear-solve stage that filled it. While sweeping it accumulates the primal residual Σ|v−z| and a clip count for the convergence check.

## Interface
Parameters:
- `DataWidth`, 32, signed Q16.16 data word
- `AddressWidth`, 5, temp RAM address width
- `VecLen`, 24, number of entries swept (0..VecLen−1)

Ports:
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  begin one sweep; sampled only in IDLE
- `busy`  out  1  high whenever state ≠ IDLE
- `done`  out  1  one-cycle pulse when the sweep completes
- `ram_address0`  out  AddressWidth  temp RAM address
- `ram_ce0`  out  1  temp RAM enable
- `ram_we0`  out  1  temp RAM write enable
- `ram_d0`  out  DataWidth  write data (clamped value z)
- `ram_q0`  in  DataWidth  registered read data, one-cycle read latency
- `bnd_idx`  out  AddressWidth  element index for bound lookup (equals `ram_address0`)
- `bnd_lo`  in  DataWidth  lower bound for `bnd_idx`, combinational
- `bnd_hi`  in  DataWidth  upper bound for `bnd_idx`, combinational
- `residual`  out  32  Σ|v−z|, unsigned Q16.16, saturating
- `clip_count`  out  AddressWidth+1  number of entries where z ≠ v

## Operation
- FSM states are IDLE, RD, WR and FIN.
- IDLE: `start`=1 moves to RD. On the same edge, idx, `residual` and `clip_count` clear to 0.
- RD: drive `ram_ce0`=1, `ram_we0`=0, address=idx. Go to WR.
- WR: drive `ram_ce0`=1, `ram_we0`=1, address=idx, with v=`ram_q0`.
  - Compute z = max(`bnd_lo`, min(v, `bnd_hi`)), so if lo>hi then z=lo.
  - Drive `ram_d0`=z.
  - `residual` += |v−z|. The difference is computed in 33 bits signed, and the add saturates at 0xFFFFFFFF.
  - `clip_count` += (z≠v).
  - If idx=VecLen−1, go to FIN; otherwise idx+1 and go back to RD.
- FIN: `done`=1, then IDLE.
- `start` is ignored outside IDLE.
- `residual` and `clip_count` hold their final values until the next accepted `start`.
- RAM and bound outputs are decoded from the state and idx. In IDLE and FIN, `ram_ce0`=`ram_we0`=0 and address=0.
- Reset values: state IDLE, idx 0, `busy`/`done`/`ram_ce0`/`ram_we0`=0, `ram_address0`/`bnd_idx`/`ram_d0`=0, `residual`=0, `clip_count`=0.
- Reset mid-sweep aborts immediately. `ram_we0` drops asynchronously and no partial write completes after reset asserts. RAM contents already written stay written.

## Timing
- Each element takes 2 cycles, RD then WR.
- A sweep takes 2·VecLen+1 cycles from the edge sampling `start` to the edge leaving FIN.
- `done` is high during the cycle after the last WR edge, i.e. cycles 2·VecLen..2·VecLen+1 after the `start` edge (48 cycles for VecLen=24).
- `residual` and `clip_count` are final and valid when `done` is high.
- `start` high during FIN is ignored. `start` is sampled again in IDLE on the next cycle.
- The RAM is read-first, so the q0 update during WR returns v again. Correctness does not depend on this.

## Configuration
- `MPC_ADMM_PROJ_RESIDUAL_EN`:
  - Defined: the residual accumulator and its saturation logic are built, as described above.
  - Undefined: `residual` is tied to 0 and the accumulator is removed. Clamping, `clip_count` and timing are unchanged.

## Structure
- Package `mpc_admm_proj_pkg` holds:
  - FSM state type (IDLE/RD/WR/FIN)
  - Q16.16 constants `Q_ONE`=0x00010000 and `RES_SAT`=0xFFFFFFFF
- Sub-module `mpc_admm_clamp_abs` (combinational): inputs v, lo, hi; outputs z, |v−z| (32-bit unsigned, saturated) and a clipped flag.
- The top level holds the FSM, idx counter, accumulators and RAM port decode.

## Test plan
- Basic sweep:
  - Setup: VecLen=24, RAM[i]=(i−12)·0.25, lo=−1.0 (0xFFFF0000), hi=1.0 (0x00010000) for all i, pulse `start`.
  - Expected: RAM[0..7]=0xFFFF0000, RAM[8..16] unchanged, RAM[17..23]=0x00010000, `clip_count`=15, `residual`=0x00100000 (16.0), `done` exactly 48 cycles after the `start` edge.
- Saturation: all RAM=0x7FFFFFFF, lo=hi=0 → all RAM=0, `clip_count`=24, `residual`=0xFFFFFFFF.
- Inverted bounds: entry v=0, lo=0.5, hi=−0.5 → z=0x00008000, residual contribution 0.5.
- Start while busy: second `start` pulse at cycle 10 → ignored, single `done` at cycle 48, RAM ops strictly alternate RD/WR over idx 0..23.
- Reset mid-sweep: assert `reset` during WR of idx 5 → `ram_we0` low immediately, `busy`=0, RAM[0..4] clamped and RAM[5..23] untouched; a new `start` then completes normally.
- Macro undefined: repeat the basic sweep → identical RAM and `clip_count`, `residual`=0.

Source files
------------

// File: rtl/mpc_admm_proj_pkg.sv
// mpc_admm_proj_pkg
// Shared types and constants for the ADMM projection stage.
//   state_t : sweep FSM states (IDLE, RD, WR, FIN)
//   Q_ONE   : 1.0 in signed Q16.16
//   RES_SAT : saturation ceiling of the unsigned Q16.16 residual
// Related build option: MPC_ADMM_PROJ_RESIDUAL_EN (see top level).
package mpc_admm_proj_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam logic [31:0] Q_ONE   = 32'h0001_0000;
  localparam logic [31:0] RES_SAT = 32'hFFFF_FFFF;

endpackage

// File: rtl/mpc_admm_clamp_abs.sv
// mpc_admm_clamp_abs
// Combinational box clamp of one Q16.16 element plus its clamp distance.
//   v_i       : value read from temp RAM (signed)
//   lo_i/hi_i : box bounds (signed); lo > hi resolves to lo
//   z_o       : max(lo, min(v, hi))
//   abs_o     : |v - z| as unsigned Q16.16, saturated to 32 bits
//   clipped_o : 1 when z differs from v
// Assumes DataWidth >= 32 so the magnitude compare against RES_SAT is exact.
module mpc_admm_clamp_abs
  import mpc_admm_proj_pkg::*;
#(
  parameter int DataWidth = 32
) (
  input  logic signed [DataWidth-1:0] v_i,
  input  logic signed [DataWidth-1:0] lo_i,
  input  logic signed [DataWidth-1:0] hi_i,
  output logic signed [DataWidth-1:0] z_o,
  output logic        [31:0]          abs_o,
  output logic                        clipped_o
);

  logic signed [DataWidth-1:0] zmin;
  logic signed [DataWidth:0]   diff;
  logic        [DataWidth:0]   mag;

  always_comb begin
    // Upper bound first, lower bound last, so an inverted box yields lo.
    zmin      = (v_i < hi_i) ? v_i : hi_i;
    z_o       = (zmin < lo_i) ? lo_i : zmin;
    // One extra bit keeps v - z exact across the full signed range.
    diff      = {v_i[DataWidth-1], v_i} - {z_o[DataWidth-1], z_o};
    mag       = diff[DataWidth] ? $unsigned(-diff) : $unsigned(diff);
    abs_o     = (mag > (DataWidth+1)'(RES_SAT)) ? RES_SAT : mag[31:0];
    clipped_o = (z_o != v_i);
  end

endmodule

// File: rtl/mpc_qp_admm_proj_update.sv
// mpc_qp_admm_proj_update
// ADMM projection sweep: reads each temp RAM entry, writes back its
// box-clamped value in place, and accumulates the primal residual
// sum|v - z| (saturating) and the number of clipped entries.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   start             : launch one sweep (accepted only in IDLE)
//   busy, done        : state != IDLE ; one-cycle completion pulse in FIN
//   ram_address0/ce0/we0/d0, ram_q0 : single-port temp RAM, 1-cycle read
//   bnd_idx, bnd_lo, bnd_hi         : bound lookup, combinational return
//   residual          : sum|v - z|, unsigned Q16.16, saturating
//   clip_count        : entries where z != v
// Build option: MPC_ADMM_PROJ_RESIDUAL_EN builds the residual accumulator;
// without it residual reads 0 and clamping/timing are unchanged.
module mpc_qp_admm_proj_update
  import mpc_admm_proj_pkg::*;
#(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 5,
  parameter int VecLen       = 24
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [AddressWidth-1:0] ram_address0,
  output logic                    ram_ce0,
  output logic                    ram_we0,
  output logic [DataWidth-1:0]    ram_d0,
  input  logic [DataWidth-1:0]    ram_q0,
  output logic [AddressWidth-1:0] bnd_idx,
  input  logic [DataWidth-1:0]    bnd_lo,
  input  logic [DataWidth-1:0]    bnd_hi,
  output logic [31:0]             residual,
  output logic [AddressWidth:0]   clip_count
);

  localparam logic [AddressWidth-1:0] LAST_IDX = AddressWidth'(VecLen - 1);

  state_t                  state_q, state_d;
  logic [AddressWidth-1:0] idx_q, idx_d;
  logic [AddressWidth:0]   clip_q, clip_d;

  logic signed [DataWidth-1:0] z;
  logic        [31:0]          absd;
  logic                        clipped;

  mpc_admm_clamp_abs #(.DataWidth(DataWidth)) u_clamp (
    .v_i      (ram_q0),
    .lo_i     (bnd_lo),
    .hi_i     (bnd_hi),
    .z_o      (z),
    .abs_o    (absd),
    .clipped_o(clipped)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      clip_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      clip_q  <= clip_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    clip_d  = clip_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RD;
          idx_d   = '0;
          clip_d  = '0;
        end
      end
      RD: state_d = WR;
      WR: begin
        clip_d = clip_q + (AddressWidth+1)'(clipped);
        if (idx_q == LAST_IDX) begin
          state_d = FIN;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = RD;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef MPC_ADMM_PROJ_RESIDUAL_EN
  logic [31:0] res_q, res_d;
  logic [32:0] res_sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) res_q <= '0;
    else       res_q <= res_d;
  end

  always_comb begin
    res_sum = {1'b0, res_q} + {1'b0, absd};
    res_d   = res_q;
    if (state_q == IDLE && start) begin
      res_d = '0;
    end else if (state_q == WR) begin
      res_d = res_sum[32] ? RES_SAT : res_sum[31:0];
    end
  end

  assign residual = res_q;
`else
  // Distance output has no consumer without the accumulator.
  logic unused_absd;
  assign unused_absd = ^absd;
  assign residual    = '0;
`endif

  // Port decode straight from registered state, so an asserted reset
  // drops the write enable without waiting for a clock edge.
  always_comb begin
    busy         = (state_q != IDLE);
    done         = (state_q == FIN);
    ram_ce0      = (state_q == RD) || (state_q == WR);
    ram_we0      = (state_q == WR);
    ram_address0 = ram_ce0 ? idx_q : '0;
    bnd_idx      = ram_address0;
    ram_d0       = ram_we0 ? z : '0;
    clip_count   = clip_q;
  end

endmodule

// File: tb/tb_mpc_qp_admm_proj_update.sv
module tb_mpc_qp_admm_proj_update;
  import mpc_admm_proj_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int VL = 24;

  logic          clk = 1'b0;
  logic          reset, start;
  logic          busy, done, ram_ce0, ram_we0;
  logic [AW-1:0] ram_address0, bnd_idx;
  logic [DW-1:0] ram_d0, ram_q0, bnd_lo, bnd_hi;
  logic [31:0]   residual;
  logic [AW:0]   clip_count;

  int vec = 0;
  int errs = 0;

  logic [DW-1:0] mem    [0:31];
  logic [DW-1:0] ld_mem [0:31];
  logic [DW-1:0] lo_a   [0:31];
  logic [DW-1:0] hi_a   [0:31];
  logic [DW-1:0] init_a [0:31];
  logic [DW-1:0] exp_a  [0:31];
  logic          ld_req;
  longint        exp_res;
  int            exp_clip;

  always #5 clk = ~clk;

  mpc_qp_admm_proj_update #(.DataWidth(DW), .AddressWidth(AW), .VecLen(VL)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .ram_address0(ram_address0), .ram_ce0(ram_ce0), .ram_we0(ram_we0),
    .ram_d0(ram_d0), .ram_q0(ram_q0), .bnd_idx(bnd_idx), .bnd_lo(bnd_lo),
    .bnd_hi(bnd_hi), .residual(residual), .clip_count(clip_count)
  );

  assign bnd_lo = lo_a[bnd_idx];
  assign bnd_hi = hi_a[bnd_idx];

  // Single-port read-first RAM with registered output.
  always @(posedge clk) begin
    if (ld_req) mem <= ld_mem;
    else if (ram_ce0) begin
      if (ram_we0) mem[ram_address0] <= ram_d0;
      ram_q0 <= mem[ram_address0];
    end
  end

  task automatic load_ram();
    for (int i = 0; i < 32; i++) ld_mem[i] = init_a[i];
    ld_req = 1'b1;
    @(negedge clk);
    ld_req = 1'b0;
  endtask

  // Reference: clamp each entry with plain integer arithmetic.
  task automatic model_calc();
    longint v, lo, hi, z, d;
    exp_res = 0;
    exp_clip = 0;
    for (int i = 0; i < VL; i++) begin
      v  = longint'($signed(init_a[i]));
      lo = longint'($signed(lo_a[i]));
      hi = longint'($signed(hi_a[i]));
      z = (v < hi) ? v : hi;
      if (z < lo) z = lo;
      d = (v > z) ? v - z : z - v;
      exp_res += d;
      if (exp_res > 64'hFFFF_FFFF) exp_res = 64'hFFFF_FFFF;
      if (z != v) exp_clip++;
      exp_a[i] = z[31:0];
    end
`ifndef MPC_ADMM_PROJ_RESIDUAL_EN
    exp_res = 0;
`endif
  endtask

  // Drives one sweep and records what the port looked like each cycle.
  task automatic run_sweep(input int extra_start, output int n_done, output int done_at,
                           output int seq_err, output logic [31:0] res_d, output logic [AW:0] clip_d);
    n_done = 0; done_at = -1; seq_err = 0; res_d = '1; clip_d = '1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (k < 2*VL) begin
        if (ram_ce0 !== 1'b1 || ram_we0 !== (k % 2 == 1) || ram_address0 !== AW'(k/2)
            || bnd_idx !== AW'(k/2) || busy !== 1'b1) seq_err++;
      end else begin
        if (ram_ce0 !== 1'b0 || ram_we0 !== 1'b0 || ram_address0 !== '0) seq_err++;
        if (busy !== (k == 2*VL)) seq_err++;
      end
      if (done === 1'b1) begin
        n_done++; done_at = k; res_d = residual; clip_d = clip_count;
      end
      start = (k == extra_start);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; ld_req = 1'b0;
    for (int i = 0; i < 32; i++) begin
      init_a[i] = '0; lo_a[i] = '0; hi_a[i] = '0;
    end
    repeat (2) @(negedge clk);
    vec++;
    if ({busy, done, ram_ce0, ram_we0} !== 4'b0 || ram_address0 !== '0 || bnd_idx !== '0
        || ram_d0 !== '0 || residual !== '0 || clip_count !== '0) begin
      errs++;
      $display("FAIL reset_state: busy=%b done=%b ce=%b we=%b addr=%0d d=%h res=%h clip=%0d, want all 0",
               busy, done, ram_ce0, ram_we0, ram_address0, ram_d0, residual, clip_count);
    end
    reset = 1'b0;
    @(negedge clk);
    vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errs++;
      $display("FAIL reset_release: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_basic_sweep();
    int nd, da, se;
    logic [31:0] rd;
    logic [AW:0] cd;
    for (int i = 0; i < 32; i++) begin
      init_a[i] = (i < VL) ? 32'((i - 12) * 16384) : '0;
      lo_a[i] = -Q_ONE; hi_a[i] = Q_ONE;
    end
    load_ram(); model_calc();
    run_sweep(-1, nd, da, se, rd, cd);
    vec++;
    if (nd != 1 || da != 2*VL) begin
      errs++; $display("FAIL basic_done: count=%0d at=%0d want 1 at %0d", nd, da, 2*VL);
    end
    vec++;
    if (se != 0) begin errs++; $display("FAIL basic_seq: %0d bad cycles want 0", se); end
    vec++;
    if (cd !== 6'd15 || clip_count !== 6'd15) begin
      errs++; $display("FAIL basic_clip: done=%0d held=%0d want 15", cd, clip_count);
    end
    vec++;
`ifdef MPC_ADMM_PROJ_RESIDUAL_EN
    if (rd !== 32'h0010_0000 || residual !== 32'h0010_0000) begin
      errs++; $display("FAIL basic_residual: %h/%h want 00100000", rd, residual);
    end
`else
    if (rd !== 32'h0 || residual !== 32'h0) begin
      errs++; $display("FAIL basic_residual: %h/%h want 0", rd, residual);
    end
`endif
    for (int i = 0; i < VL; i++) begin
      vec++;
      if (mem[i] !== exp_a[i]) begin
        errs++; $display("FAIL basic_ram[%0d]: %h want %h", i, mem[i], exp_a[i]);
      end
    end
    vec++;
    if (mem[0] !== 32'hFFFF_0000 || mem[12] !== 32'h0 || mem[23] !== 32'h0001_0000) begin
      errs++; $display("FAIL basic_fixed: %h %h %h want FFFF0000 0 00010000", mem[0], mem[12], mem[23]);
    end
  endtask

  task automatic test_saturation();
    int nd, da, se;
    logic [31:0] rd;
    logic [AW:0] cd;
    for (int i = 0; i < 32; i++) begin
      init_a[i] = 32'h7FFF_FFFF; lo_a[i] = '0; hi_a[i] = '0;
    end
    load_ram(); model_calc();
    run_sweep(-1, nd, da, se, rd, cd);
    vec++;
    if (cd !== 6'd24 || rd !== exp_res[31:0]) begin
      errs++; $display("FAIL sat_acc: clip=%0d res=%h want 24 %h", cd, rd, exp_res[31:0]);
    end
`ifdef MPC_ADMM_PROJ_RESIDUAL_EN
    vec++;
    if (residual !== 32'hFFFF_FFFF) begin
      errs++; $display("FAIL sat_residual: %h want FFFFFFFF", residual);
    end
`endif
    for (int i = 0; i < VL; i++) begin
      vec++;
      if (mem[i] !== 32'h0) begin errs++; $display("FAIL sat_ram[%0d]: %h want 0", i, mem[i]); end
    end
  endtask

  task automatic test_random();
    int nd, da, se;
    logic [31:0] rd, a, b;
    logic [AW:0] cd;
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 32; i++) begin
        init_a[i] = (it == 0) ? $urandom : 32'($signed($urandom_range(0, 32'h0006_0000)) - 32'sh0003_0000);
        a = 32'($signed($urandom_range(0, 32'h0004_0000)) - 32'sh0002_0000);
        b = 32'($signed($urandom_range(0, 32'h0004_0000)) - 32'sh0002_0000);
        // Mostly ordered boxes, with some deliberately inverted ones.
        if ($urandom_range(0, 3) == 0 || $signed(a) <= $signed(b)) begin lo_a[i] = a; hi_a[i] = b; end
        else begin lo_a[i] = b; hi_a[i] = a; end
      end
      init_a[3] = '0; lo_a[3] = 32'h0000_8000; hi_a[3] = 32'hFFFF_8000;
      load_ram(); model_calc();
      run_sweep(-1, nd, da, se, rd, cd);
      vec++;
      if (nd != 1 || da != 2*VL || se != 0) begin
        errs++; $display("FAIL rand_timing it%0d: done=%0d at=%0d seq=%0d", it, nd, da, se);
      end
      vec++;
      if (rd !== exp_res[31:0] || cd !== (AW+1)'(exp_clip)) begin
        errs++; $display("FAIL rand_acc it%0d: res=%h clip=%0d want %h %0d", it, rd, cd, exp_res[31:0], exp_clip);
      end
      vec++;
      if (mem[3] !== 32'h0000_8000) begin
        errs++; $display("FAIL inverted_bounds it%0d: %h want 00008000", it, mem[3]);
      end
      for (int i = 0; i < VL; i++) begin
        vec++;
        if (mem[i] !== exp_a[i]) begin
          errs++; $display("FAIL rand_ram it%0d [%0d]: %h want %h", it, i, mem[i], exp_a[i]);
        end
      end
    end
  endtask

  task automatic test_start_while_busy();
    int nd, da, se;
    logic [31:0] rd;
    logic [AW:0] cd;
    for (int i = 0; i < 32; i++) begin
      init_a[i] = (i < VL) ? 32'((i - 12) * 16384) : '0;
      lo_a[i] = -Q_ONE; hi_a[i] = Q_ONE;
    end
    load_ram(); model_calc();
    run_sweep(10, nd, da, se, rd, cd);
    vec++;
    if (nd != 1 || da != 2*VL || se != 0) begin
      errs++; $display("FAIL busy_start: done=%0d at=%0d seq=%0d want 1 %0d 0", nd, da, se, 2*VL);
    end
    vec++;
    if (cd !== (AW+1)'(exp_clip) || rd !== exp_res[31:0]) begin
      errs++; $display("FAIL busy_acc: clip=%0d res=%h want %0d %h", cd, rd, exp_clip, exp_res[31:0]);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int nd, da, se;
    logic [31:0] rd;
    logic [AW:0] cd;
    bit found;
    for (int i = 0; i < 32; i++) begin
      init_a[i] = 32'($signed($urandom_range(0, 32'h0006_0000)) - 32'sh0003_0000);
      lo_a[i] = -Q_ONE; hi_a[i] = Q_ONE;
    end
    init_a[5] = 32'h0005_0000;
    load_ram(); model_calc();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      if (ram_we0 === 1'b1 && ram_address0 === AW'(5)) found = 1;
      else @(negedge clk);
    end
    vec++;
    if (!found) begin errs++; $display("FAIL rst_find_wr5: WR of idx 5 never seen"); end
    reset = 1'b1;
    #1;
    vec++;
    if (ram_we0 !== 1'b0 || ram_ce0 !== 1'b0 || busy !== 1'b0) begin
      errs++; $display("FAIL rst_async: we=%b ce=%b busy=%b want 0 0 0", ram_we0, ram_ce0, busy);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < VL; i++) begin
      vec++;
      if (mem[i] !== ((i < 5) ? exp_a[i] : init_a[i])) begin
        errs++; $display("FAIL rst_ram[%0d]: %h want %h", i, mem[i], (i < 5) ? exp_a[i] : init_a[i]);
      end
    end
    for (int i = 0; i < 32; i++) init_a[i] = mem[i];
    model_calc();
    run_sweep(-1, nd, da, se, rd, cd);
    vec++;
    if (nd != 1 || da != 2*VL || se != 0 || cd !== (AW+1)'(exp_clip) || rd !== exp_res[31:0]) begin
      errs++; $display("FAIL rst_resweep: done=%0d at=%0d seq=%0d clip=%0d res=%h want clip %0d res %h",
                       nd, da, se, cd, rd, exp_clip, exp_res[31:0]);
    end
    for (int i = 0; i < VL; i++) begin
      vec++;
      if (mem[i] !== exp_a[i]) begin
        errs++; $display("FAIL rst_resweep_ram[%0d]: %h want %h", i, mem[i], exp_a[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_sweep();
    test_saturation();
    test_random();
    test_start_while_busy();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
